// File: rtl/control_canales_pwm_pkg.sv
// Shared types and constants for the PWM channel command controller.
package control_canales_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSO  = 2'd1,
    ESPERA = 2'd2,
    REPITE = 2'd3
  } estado_t;

  localparam int unsigned CANAL_W  = 3;
  localparam int unsigned DUTY_W   = 4;
  localparam logic [DUTY_W-1:0] DUTY_MIN = 4'd0;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;

  function automatic logic [7:0] one_hot8(input logic [CANAL_W-1:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/control_canales_pwm_if.sv
// Button inputs and channel/duty outputs of the PWM command controller.
interface control_canales_pwm_if
  import control_canales_pwm_pkg::*;
#(
  parameter int unsigned N_CANALES = 4
);
  logic                          btn_up;
  logic                          btn_down;
  logic                          btn_canal;
  logic [N_CANALES-1:0]          chip_select;
  logic                          up;
  logic                          down;
  logic [CANAL_W-1:0]            canal_actual;
  logic [DUTY_W*N_CANALES-1:0]   ciclo_sombra;

  modport master (
    output btn_up, btn_down, btn_canal,
    input  chip_select, up, down, canal_actual, ciclo_sombra
  );

  modport slave (
    input  btn_up, btn_down, btn_canal,
    output chip_select, up, down, canal_actual, ciclo_sombra
  );
endinterface

// File: rtl/control_canales_pwm_antirrebote.sv
// Debouncer: the level follows the input only after DEBOUNCE consecutive
// samples of the new value; any sample equal to the current level restarts.
module antirrebote #(
  parameter int unsigned DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic nivel
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      nivel <= 1'b0;
    end else if (din == nivel) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
      cnt   <= '0;
      nivel <= din;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/control_canales_pwm.sv
// Button-driven duty command generator: debounced up/down with auto-repeat,
// channel selection and saturating 4-bit shadow duty per channel.
module control_canales_pwm
  import control_canales_pwm_pkg::*;
#(
  parameter int unsigned N_CANALES   = 4,
  parameter int unsigned DEBOUNCE    = 1_000_000,
  parameter int unsigned RETARDO_REP = 50_000_000,
  parameter int unsigned PERIODO_REP = 10_000_000
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  control_canales_pwm_if.slave  bus
);
  localparam int unsigned REP_W = $clog2(RETARDO_REP + PERIODO_REP + 1);

  // Bit 0 = up, bit 1 = down, bit 2 = channel
  logic [2:0] sync1, sync2, armed, db, db_q, rise;

  estado_t            estado, estado_n;
  logic               dir, dir_n;
  logic [REP_W-1:0]   cnt, cnt_n;
  logic [CANAL_W-1:0] canal, canal_n;
  logic [N_CANALES-1:0] chip_select;
  logic               up, down, up_n, down_n, fire, held;
  logic [DUTY_W-1:0]  sombra [N_CANALES];
  logic [DUTY_W-1:0]  sel;

  // Synchronizers reset high so a button held through reset is never seen as a fresh press
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      armed <= 3'b000;
      db_q  <= 3'b000;
    end else begin
      sync1 <= {bus.btn_canal, bus.btn_down, bus.btn_up};
      sync2 <= sync1;
      armed <= armed | ~sync2;
      db_q  <= db;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    antirrebote #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk_100MHz),
      .rst   (rst),
      .din   (sync2[i]),
      .nivel (db[i])
    );
  end

  assign rise = db & ~db_q & armed;

  always_comb begin
    estado_n = estado;
    dir_n    = dir;
    canal_n  = canal;
    cnt_n    = cnt + REP_W'(1);
    fire     = 1'b0;
    sel      = '0;
    held     = dir ? (db[1] & ~db[0]) : (db[0] & ~db[1]);
    for (int k = 0; k < int'(N_CANALES); k++) begin
      if (canal == CANAL_W'(k)) sel = sombra[k];
    end
    case (estado)
      IDLE: begin
        cnt_n = '0;
        if ((rise[0] ^ rise[1]) && !(db[0] && db[1])) begin
          estado_n = PULSO;
          dir_n    = rise[1];
          fire     = 1'b1;
        end else if (rise[2]) begin
          canal_n = (canal == CANAL_W'(N_CANALES - 1)) ? '0 : canal + CANAL_W'(1);
        end
      end
      PULSO: estado_n = ESPERA;
      ESPERA: begin
        if (!held) begin
          estado_n = IDLE;
        end else if (cnt == REP_W'(RETARDO_REP - 1)) begin
          estado_n = REPITE;
          fire     = 1'b1;
        end
      end
      REPITE: begin
        if (!held) begin
          estado_n = IDLE;
        end else if (cnt == REP_W'(PERIODO_REP - 1)) begin
          fire = 1'b1;
        end
      end
      default: estado_n = IDLE;
    endcase
    if (fire) cnt_n = '0;
    // Saturated steps still restart the repeat timer but produce no pulse
    up_n   = fire && !dir_n && (sel != DUTY_MAX);
    down_n = fire &&  dir_n && (sel != DUTY_MIN);
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      estado      <= IDLE;
      dir         <= 1'b0;
      cnt         <= '0;
      canal       <= '0;
      chip_select <= N_CANALES'(1);
      up          <= 1'b0;
      down        <= 1'b0;
      for (int k = 0; k < int'(N_CANALES); k++) sombra[k] <= DUTY_MIN;
    end else begin
      estado      <= estado_n;
      dir         <= dir_n;
      cnt         <= cnt_n;
      canal       <= canal_n;
      chip_select <= N_CANALES'(one_hot8(canal_n));
      up          <= up_n;
      down        <= down_n;
      for (int k = 0; k < int'(N_CANALES); k++) begin
        if (canal == CANAL_W'(k)) begin
          if (up_n)        sombra[k] <= sel + DUTY_W'(1);
          else if (down_n) sombra[k] <= sel - DUTY_W'(1);
        end
      end
    end
  end

  assign bus.chip_select  = chip_select;
  assign bus.up           = up;
  assign bus.down         = down;
  assign bus.canal_actual = canal;
  for (genvar k = 0; k < int'(N_CANALES); k++) begin : g_sombra
    assign bus.ciclo_sombra[DUTY_W*k +: DUTY_W] = sombra[k];
  end
endmodule

// File: tb/tb_control_canales_pwm.sv
// Directed bench for control_canales_pwm with short debounce/repeat timings.
module tb_control_canales_pwm;
  import control_canales_pwm_pkg::*;

  localparam int unsigned N = 4;

  logic clk_100MHz = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_up  = 0;
  int   n_down = 0;
  int   t_up[$];
  int   n0, d0;

  control_canales_pwm_if #(.N_CANALES(N)) bus ();

  control_canales_pwm #(
    .N_CANALES   (N),
    .DEBOUNCE    (4),
    .RETARDO_REP (20),
    .PERIODO_REP (8)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  always @(negedge clk_100MHz) begin
    if (bus.up) begin
      n_up = n_up + 1;
      t_up.push_back(cyc);
    end
    if (bus.down) n_down = n_down + 1;
    if (bus.up && bus.down) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL up_down_overlap: up=1 down=1 at cycle %0d, required never both", cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic press_up(input int h);
    @(negedge clk_100MHz); bus.btn_up = 1'b1;
    idle(h);               bus.btn_up = 1'b0;
    idle(20);
  endtask

  task automatic press_down(input int h);
    @(negedge clk_100MHz); bus.btn_down = 1'b1;
    idle(h);               bus.btn_down = 1'b0;
    idle(20);
  endtask

  task automatic press_canal();
    @(negedge clk_100MHz); bus.btn_canal = 1'b1;
    idle(10);              bus.btn_canal = 1'b0;
    idle(20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_canal"}, 32'(bus.canal_actual), 32'd0);
    check({tag, "_cs"},    32'(bus.chip_select),  32'b0001);
    check({tag, "_up"},    32'(bus.up),           32'd0);
    check({tag, "_down"},  32'(bus.down),         32'd0);
    check({tag, "_sombra"}, 32'(bus.ciclo_sombra), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_canal = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(10);

    // Glitch shorter than debounce window
    press_up(3);
    check("glitch_no_pulse", 32'(n_up), 32'd0);

    press_up(10);
    check("single_pulse", 32'(n_up), 32'd1);
    check("single_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd1);

    // Auto-repeat: first pulse, +20, then every 8
    t_up.delete();
    n0 = n_up;
    press_up(60);
    check("repeat_count", 32'(n_up - n0), 32'd6);
    for (int i = 1; i < t_up.size(); i++)
      check($sformatf("repeat_gap%0d", i), 32'(t_up[i] - t_up[i-1]), (i == 1) ? 32'd20 : 32'd8);
    check("repeat_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd7);

    // Drive to saturation at 15
    n0 = n_up;
    press_up(120);
    check("sat_up_count", 32'(n_up - n0), 32'd8);
    check("sat_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd15);
    n0 = n_up;
    press_up(10);
    check("at15_no_pulse", 32'(n_up - n0), 32'd0);
    check("at15_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd15);

    d0 = n_down;
    press_down(10);
    check("down_pulse", 32'(n_down - d0), 32'd1);
    check("down_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd14);

    // Channel stepping, with a down press at zero on channel 1
    press_canal();
    check("canal1", 32'(bus.canal_actual), 32'd1);
    check("cs1", 32'(bus.chip_select), 32'b0010);
    d0 = n_down;
    press_down(10);
    check("at0_no_pulse", 32'(n_down - d0), 32'd0);
    check("at0_sombra1", 32'(bus.ciclo_sombra[7:4]), 32'd0);
    press_canal();
    check("canal2", 32'(bus.canal_actual), 32'd2);
    check("cs2", 32'(bus.chip_select), 32'b0100);
    press_canal();
    check("canal3", 32'(bus.canal_actual), 32'd3);
    check("cs3", 32'(bus.chip_select), 32'b1000);
    press_canal();
    check("canal0", 32'(bus.canal_actual), 32'd0);
    check("cs0", 32'(bus.chip_select), 32'b0001);

    // Channel press while up held is ignored
    n0 = n_up;
    @(negedge clk_100MHz); bus.btn_up = 1'b1;
    idle(10); bus.btn_canal = 1'b1;
    idle(10); bus.btn_canal = 1'b0;
    idle(10); bus.btn_up = 1'b0;
    idle(20);
    check("canal_ignored", 32'(bus.canal_actual), 32'd0);
    check("cs_ignored", 32'(bus.chip_select), 32'b0001);
    check("held_up_count", 32'(n_up - n0), 32'd1);
    check("held_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd15);

    // Both buttons together
    n0 = n_up;
    d0 = n_down;
    @(negedge clk_100MHz); bus.btn_up = 1'b1; bus.btn_down = 1'b1;
    idle(30); bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    idle(20);
    check("both_no_up", 32'(n_up - n0), 32'd0);
    check("both_no_down", 32'(n_down - d0), 32'd0);

    // Reset during REPITE with up still held
    press_canal();
    n0 = n_up;
    @(negedge clk_100MHz); bus.btn_up = 1'b1;
    idle(40);
    check("pre_rst_count", 32'(n_up - n0), 32'd3);
    check("pre_rst_sombra1", 32'(bus.ciclo_sombra[7:4]), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    idle(3);
    rst = 1'b0;
    n0 = n_up;
    idle(40);
    check("held_after_rst", 32'(n_up - n0), 32'd0);
    bus.btn_up = 1'b0;
    idle(20);
    check("release_after_rst", 32'(n_up - n0), 32'd0);
    press_up(10);
    check("repress_count", 32'(n_up - n0), 32'd1);
    check("repress_sombra0", 32'(bus.ciclo_sombra[3:0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
